rle_decoder: RTL and testbench
==============================

RLE_DECODER -- requirements
Module: rle_decoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 9, signed sample width.
REQ-002 The block SHALL have parameter CNT_W, default 8, run-count width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  pair-side valid.
REQ-006 The block SHALL have port in_ready  output  1  pair-side ready.
REQ-007 The block SHALL have port in_value  input  DATA_W  signed run value.
REQ-008 The block SHALL have port in_count  input  CNT_W  run length; 0 encodes 2^CNT_W.
REQ-009 The block SHALL have port out_valid  output  1  sample-side valid.
REQ-010 The block SHALL have port out_ready  input  1  sample-side ready.
REQ-011 The block SHALL have port out_sample  output  DATA_W  signed expanded sample.
REQ-012 The block SHALL have port busy  output  1  high while a run is being emitted.

Function
REQ-013 Input handshake: a pair transfers on a rising edge with in_valid=1 and in_ready=1; the output handshake uses out_valid/out_ready the same way.
REQ-014 FSM states: IDLE (no run held) and RUN (run held, remaining >= 1).
REQ-015 IDLE: in_ready=1 and out_valid=0; an accepted pair loads the value register and the remaining counter, and the FSM goes to RUN.
REQ-016 Remaining counter: CNT_W+1 bits wide; loads in_count, or 2^CNT_W when in_count=0.
REQ-017 RUN: out_valid=1 and out_sample = held value; each output transfer decrements remaining by 1.
REQ-018 Latency: a pair accepted at edge N produces its first sample valid in the cycle after edge N; the outputs are driven only from registers.
REQ-019 In RUN, in_ready = (remaining==1) && out_ready, so the last sample of one run and the next pair acceptance share one edge.
REQ-020 Last sample with a simultaneous new pair: load the new pair and stay in RUN; no bubble cycle.
REQ-021 Last sample with no new pair: go to IDLE; out_valid falls at that edge.
REQ-022 Backpressure: while out_ready=0, out_sample, out_valid and remaining SHALL hold; no sample is dropped or duplicated.
REQ-023 in_value/in_count are ignored when no transfer occurs; X on them when in_valid=0 SHALL NOT propagate.
REQ-024 busy = (state==RUN).
REQ-025 Total samples out SHALL equal the sum of the decoded run lengths, with values in order; exact inverse of the team's RLE encoder stream.

Reset
REQ-026 While rst=1 the state SHALL be IDLE, remaining=0, value register=0, out_valid=0, out_sample=0, busy=0 and in_ready=0.
REQ-027 rst SHALL take effect asynchronously; release is synchronised to clk, and in_ready rises in the first cycle after release.
REQ-028 Reset mid-run SHALL discard the held run; no residual samples after release.

Structure
REQ-029 A shared package rle_pkg SHALL hold DATA_W, CNT_W and the FSM state typedef (IDLE, RUN); the team's encoder reuses the widths.
REQ-030 The remaining-count load/decrement logic SHALL be one sub-module, rle_run_counter (load, dec, zero-length-means-max mapping, is_last flag).
REQ-031 Target size: 120-400 RTL lines.

Verification
REQ-032 Pair (value=-5, count=3) with out_ready=1 -> samples -5,-5,-5 on three consecutive cycles, then out_valid=0.
REQ-033 Back-to-back pairs (7,2),(100,1),(-256,2) with in_valid held -> samples 7,7,100,-256,-256 with no gap cycles.
REQ-034 Pair (255,0) -> exactly 256 samples of 255, then busy=0.
REQ-035 Pair (12,4) with out_ready toggling 1,0,0,1,1,0,1 -> exactly four samples of 12, held stable during stalls.
REQ-036 Assert rst after 2 of 5 samples of (-1,5) -> out_valid=0 immediately; no further -1 samples after release; the next pair (3,1) yields a single 3.
REQ-037 Random encoder stream into rle_decoder -> output SHALL match the original encoder input sequence sample-for-sample.

Source files
------------

// File: rtl/rle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rle_pkg : widths and FSM state type shared by RLE encoder/decoder     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package rle_pkg;
    localparam int DATA_W = 9;
    localparam int CNT_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage
`default_nettype wire

// File: rtl/rle_run_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rle_run_counter : remaining-sample counter; zero count means 2^CNT_W  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rle_run_counter
    import rle_pkg::*;
#(
    parameter int CNT_W = rle_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_count,
    output logic [CNT_W:0]   remaining,
    output logic             is_last
);
    localparam logic [CNT_W:0] c_one = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] c_max = {1'b1, {CNT_W{1'b0}}};

    logic [CNT_W:0] r_remaining;

    // Load wins over decrement: the last sample of a run and the next pair share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (load) begin
            r_remaining <= (load_count == '0) ? c_max : {1'b0, load_count};
        end else if (dec) begin
            r_remaining <= r_remaining - c_one;
        end
    end

    assign remaining = r_remaining;
    assign is_last   = (r_remaining == c_one);
endmodule
`default_nettype wire

// File: rtl/rle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rle_decoder : expands (value, count) pairs into a sample stream       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rle_decoder
    import rle_pkg::*;
#(
    parameter int DATA_W = rle_pkg::DATA_W,
    parameter int CNT_W  = rle_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_value,
    input  logic        [CNT_W-1:0]  in_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     busy
);
    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_value;
    logic                      r_alive;
    logic [CNT_W:0]            w_remaining;
    logic                      w_is_last;
    logic                      w_in_fire;
    logic                      w_out_fire;

    // r_alive keeps in_ready low until the first edge after reset release.
    assign in_ready   = (r_state == IDLE) ? r_alive : (w_is_last && out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = (r_state == RUN) && out_ready;

    rle_run_counter #(
        .CNT_W (CNT_W)
    ) u_run_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (w_in_fire),
        .dec        (w_out_fire),
        .load_count (in_count),
        .remaining  (w_remaining),
        .is_last    (w_is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_value <= '0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_value <= in_value;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_out_fire && w_is_last) begin
                        if (w_in_fire) begin
                            r_value <= in_value;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid  = (r_state == RUN);
    assign out_sample = r_value;
    assign busy       = (r_state == RUN);
endmodule
`default_nettype wire

// File: tb/tb_rle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rle_decoder : directed and encoder-stream checks of rle_decoder    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_rle_decoder;
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [8:0] in_value;
    logic        [7:0] in_count;
    logic              out_valid;
    logic              out_ready;
    logic signed [8:0] out_sample;
    logic              busy;

    int errors = 0;
    int checks = 0;

    int pv[$];
    int pc[$];
    bit rpat[$];
    int got[$];
    int gotcyc[$];
    int stall_bad;
    bit done;

    always #5 clk = ~clk;

    rle_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_count   (in_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .busy       (busy)
    );

    // Feeds pv/pc pairs, applies rpat as out_ready (1 past its end), collects samples.
    task automatic run(input int maxcyc);
        bit               prev_stall;
        logic signed [8:0] prev_val;
        prev_stall = 1'b0;
        prev_val   = '0;
        got.delete();
        gotcyc.delete();
        stall_bad = 0;
        done      = 1'b0;
        for (int k = 0; k < maxcyc; k++) begin
            if (pv.size() == 0 && out_valid !== 1'b1) begin
                done = 1'b1;
                break;
            end
            in_valid  = (pv.size() > 0);
            in_value  = in_valid ? 9'(pv[0]) : 'x;
            in_count  = in_valid ? 8'(pc[0]) : 'x;
            out_ready = (k < rpat.size()) ? rpat[k] : 1'b1;
            #1;
            if (prev_stall && (out_valid !== 1'b1 || out_sample !== prev_val))
                stall_bad++;
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_val   = out_sample;
            if (in_valid && in_ready === 1'b1) begin
                void'(pv.pop_front());
                void'(pc.pop_front());
            end
            if (out_valid === 1'b1 && out_ready) begin
                got.push_back(int'(out_sample));
                gotcyc.push_back(k);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_value  = 'x;
        in_count  = 'x;
        out_ready = 1'b1;
        rpat.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_value = 'x; in_count = 'x; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_sample !== 9'sd0) begin errors++; $display("FAIL reset_out_sample got=%0d exp=0", out_sample); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_run;
        int gaps;
        pv = '{-5}; pc = '{3};
        run(50);
        checks++; if (!done) begin errors++; $display("FAIL single_timeout got=busy exp=idle"); end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL single_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] != -5) begin errors++; $display("FAIL single_value[%0d] got=%0d exp=-5", i, got[i]); end
        end
        gaps = 0;
        for (int i = 1; i < gotcyc.size(); i++) if (gotcyc[i] != gotcyc[i-1] + 1) gaps++;
        checks++; if (gaps != 0) begin errors++; $display("FAIL single_gaps got=%0d exp=0", gaps); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end got=%b%b exp=00", out_valid, busy); end
    endtask

    task automatic test_back_to_back;
        int exp[5] = '{7, 7, 100, -256, -256};
        int gaps;
        pv = '{7, 100, -256}; pc = '{2, 1, 2};
        run(50);
        checks++; if (!done) begin errors++; $display("FAIL b2b_timeout got=busy exp=idle"); end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] != exp[i]) begin errors++; $display("FAIL b2b_value[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
        gaps = 0;
        for (int i = 1; i < gotcyc.size(); i++) if (gotcyc[i] != gotcyc[i-1] + 1) gaps++;
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
    endtask

    task automatic test_max_run;
        int bad;
        pv = '{255}; pc = '{0};
        run(400);
        checks++; if (!done) begin errors++; $display("FAIL max_timeout got=busy exp=idle"); end
        checks++; if (got.size() != 256) begin errors++; $display("FAIL max_count got=%0d exp=256", got.size()); end
        bad = 0;
        foreach (got[i]) if (got[i] != 255) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL max_values got=%0d wrong exp=0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure;
        int bad;
        pv = '{12}; pc = '{4};
        rpat = '{1, 1, 0, 0, 1, 1, 0, 1};
        run(50);
        checks++; if (!done) begin errors++; $display("FAIL bp_timeout got=busy exp=idle"); end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        bad = 0;
        foreach (got[i]) if (got[i] != 12) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_values got=%0d wrong exp=0", bad); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_hold got=%0d exp=0", stall_bad); end
    endtask

    task automatic test_reset_midrun;
        int seen;
        in_valid = 1'b1; in_value = -9'sd1; in_count = 8'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_value = 'x; in_count = 'x;
        checks++; if (out_valid !== 1'b1 || out_sample !== -9'sd1) begin errors++; $display("FAIL rstrun_first got=%b/%0d exp=1/-1", out_valid, out_sample); end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstrun_async got=%b%b exp=00", out_valid, busy); end
        checks++; if (out_sample !== 9'sd0) begin errors++; $display("FAIL rstrun_sample got=%0d exp=0", out_sample); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstrun_residual got=%0d exp=0", seen); end
        pv = '{3}; pc = '{1};
        run(20);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL rstrun_next_count got=%0d exp=1", got.size()); end
        checks++; if (got.size() > 0 && got[0] != 3) begin errors++; $display("FAIL rstrun_next_value got=%0d exp=3", got[0]); end
    endtask

    task automatic test_encoder_stream;
        int exp[$];
        int bad;
        int len;
        int val;
        for (int r = 0; r < 24; r++) begin
            len = (r % 8 == 5) ? 256 : int'($urandom_range(1, 30));
            val = int'($urandom_range(0, 511)) - 256;
            pv.push_back(val);
            pc.push_back(len % 256);
            repeat (len) exp.push_back(val);
        end
        for (int k = 0; k < 4000; k++) rpat.push_back(bit'($urandom_range(0, 1)));
        run(6000);
        checks++; if (!done) begin errors++; $display("FAIL enc_timeout got=busy exp=idle"); end
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL enc_count got=%0d exp=%0d", got.size(), exp.size()); end
        bad = 0;
        for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] != exp[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL enc_values got=%0d wrong exp=0", bad); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL enc_stall_hold got=%0d exp=0", stall_bad); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_run();
        test_back_to_back();
        test_max_run();
        test_backpressure();
        test_reset_midrun();
        test_encoder_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
